sram_ctrl: RTL and testbench

Responder for the 16-bit SRAM request port driven by the UART control interface (`sram_req/sram_wr/sram_rd/sram_addr/sram_wdata` → `sram_rdata/sram_busy/sram_data_valid`). Converts single-cycle read/write commands into correctly timed asynchronous SRAM cycles on the board's external 16-bit SRAM. Sits between `control_interface` and the SRAM pins; the bidirectional data tristate lives at the top level.

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the asynchronous SRAM responder.
// State encoding, default strobe timing and the idle strobe pattern.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    RD_DONE   = 3'd2,
    WR_SETUP  = 3'd3,
    WR_PULSE  = 3'd4,
    WR_HOLD   = 3'd5
  } state_t;

  localparam int unsigned WAIT_CYCLES_DEF = 2;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
  } strobes_t;

  localparam strobes_t STROBE_IDLE = '1;

endpackage

// File: rtl/sram_ctrl.sv
// Turns single-cycle read/write commands into timed asynchronous SRAM cycles.
// Every pin-facing output is registered from the next-state decode.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              data_valid,
  output logic [ADDR_W-1:0] sram_a,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  strobes_t   strb, strb_nxt;
  logic       dq_oe_nxt, busy_nxt, dv_nxt;

  assign accept = req && !busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept && wr) begin
          state_nxt = WR_SETUP;
        end else if (accept && rd) begin
          state_nxt = RD_ACCESS;
          cnt_nxt   = WAIT_LOAD;
        end
      end
      RD_ACCESS: begin
        if (cnt == '0) state_nxt = RD_DONE;
        else           cnt_nxt   = cnt - 4'd1;
      end
      RD_DONE:  state_nxt = IDLE;
      WR_SETUP: begin
        state_nxt = WR_PULSE;
        cnt_nxt   = WAIT_LOAD;
      end
      WR_PULSE: begin
        if (cnt == '0) state_nxt = WR_HOLD;
        else           cnt_nxt   = cnt - 4'd1;
      end
      WR_HOLD:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so the registered
  // pins line up with the state itself, not one cycle behind it.
  always_comb begin
    strb_nxt  = STROBE_IDLE;
    dq_oe_nxt = 1'b0;
    busy_nxt  = 1'b1;
    dv_nxt    = 1'b0;
    case (state_nxt)
      IDLE: busy_nxt = 1'b0;
      RD_ACCESS: begin
        strb_nxt.ce_n = 1'b0;
        strb_nxt.oe_n = 1'b0;
        strb_nxt.ub_n = 1'b0;
        strb_nxt.lb_n = 1'b0;
      end
      RD_DONE: dv_nxt = 1'b1;
      WR_SETUP, WR_HOLD: begin
        strb_nxt.ce_n = 1'b0;
        strb_nxt.ub_n = 1'b0;
        strb_nxt.lb_n = 1'b0;
        dq_oe_nxt     = 1'b1;
      end
      WR_PULSE: begin
        strb_nxt.ce_n = 1'b0;
        strb_nxt.we_n = 1'b0;
        strb_nxt.ub_n = 1'b0;
        strb_nxt.lb_n = 1'b0;
        dq_oe_nxt     = 1'b1;
      end
      default: busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strb       <= STROBE_IDLE;
      sram_dq_oe <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      rdata      <= '0;
    end else begin
      strb       <= strb_nxt;
      sram_dq_oe <= dq_oe_nxt;
      busy       <= busy_nxt;
      data_valid <= dv_nxt;
      if (state == IDLE && state_nxt != IDLE) begin
        sram_a    <= addr;
        sram_dq_o <= wdata;
      end
      if (state == RD_ACCESS && cnt == '0) rdata <= sram_dq_i;
    end
  end

  assign sram_ce_n = strb.ce_n;
  assign sram_oe_n = strb.oe_n;
  assign sram_we_n = strb.we_n;
  assign sram_ub_n = strb.ub_n;
  assign sram_lb_n = strb.lb_n;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl against a pin-level SRAM and a word-level
// memory model of what the array should contain.
module tb_sram_ctrl;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n, req, wr, rd;
  logic [15:0] addr, wdata, rdata;
  logic        busy, data_valid;
  logic [15:0] sram_a, sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  sram_ctrl #(.ADDR_W(16), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .rd(rd), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .data_valid(data_valid),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #10 clk = ~clk;

  // Pin-level asynchronous SRAM
  logic [15:0] mem [0:65535];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 16'hDEAD;
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_a] <= sram_dq_o;

  // Word-level expectation of array contents
  logic [15:0] ref_mem [0:65535];

  int          checks = 0;
  int          errors = 0;
  int          we_events = 0;
  int          overlap_err = 0;
  logic        prev_we = 1'b1;
  logic [31:0] wlog[$];

  always @(negedge clk) begin
    if (!sram_we_n && prev_we) begin
      we_events <= we_events + 1;
      wlog.push_back({sram_a, sram_dq_o});
    end
    if ((!sram_oe_n && !sram_we_n) || (sram_dq_oe && !sram_oe_n))
      overlap_err <= overlap_err + 1;
    prev_we <= sram_we_n;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic also_rd);
    int   busy_n = 0, wel = 0, dv = 0, ev0;
    logic done = 1'b0;
    ev0 = we_events;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; rd = also_rd; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!sram_we_n) wel++;
      if (data_valid) dv++;
      if (busy) busy_n++;
      else begin done = 1'b1; break; end
    end
    check("wr_done", 32'(done), 32'd1);
    check("wr_busy_cycles", busy_n, W + 2);
    check("wr_we_low_cycles", wel, W);
    check("wr_no_data_valid", dv, 0);
    check("wr_strobe_count", we_events - ev0, 1);
    if (wlog.size() > 0) check("wr_addr_data", wlog[$], {a, d});
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [15:0] a, input logic inject);
    int          busy_n = 0, dv = 0, lat = 0;
    logic [15:0] got = '0;
    logic        done = 1'b0;
    @(negedge clk);
    req = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    rd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inject) rd = (i == 0);
      if (data_valid) begin dv++; lat = i + 1; got = rdata; end
      if (busy) busy_n++;
      else begin done = 1'b1; break; end
    end
    rd = 1'b0;
    check("rd_done", 32'(done), 32'd1);
    check("rd_busy_cycles", busy_n, W + 1);
    check("rd_dv_count", dv, 1);
    check("rd_latency", lat, W + 1);
    check("rd_data", got, ref_mem[a]);
  endtask

  task automatic quiet_window(input string tag, input int ev0);
    int b = 0, dv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) b++;
      if (data_valid) dv++;
    end
    check({tag, "_busy"}, b, 0);
    check({tag, "_dv"}, dv, 0);
    check({tag, "_we"}, we_events - ev0, 0);
  endtask

  initial begin
    int          ev0, s0, nidle;
    logic        seen;
    logic [15:0] a, d;

    rst_n = 1'b0; req = 1'b1; wr = 1'b0; rd = 1'b1; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'h1f);
    check("rst_busy", busy, 0);
    check("rst_dv", data_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_dq_oe", sram_dq_oe, 0);
    check("rst_addr", sram_a, 0);
    rst_n = 1'b1; rd = 1'b0;

    do_write(16'h1234, 16'hBEEF, 1'b0);
    do_read(16'h1234, 1'b0);

    // Master holds wr until it sees busy drop; the extra accept is expected
    ev0 = we_events; s0 = wlog.size(); seen = 1'b0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 16'h0010; wdata = 16'h55AA;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    @(posedge clk); #1;
    wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("held_wr_count", we_events - ev0, 2);
    for (int i = s0; i < wlog.size(); i++) check("held_wr_entry", wlog[i], {16'h0010, 16'h55AA});
    ref_mem[16'h0010] = 16'h55AA;

    do_read(16'h1234, 1'b1);
    quiet_window("rd_during_busy", we_events);

    ev0 = we_events;
    @(negedge clk);
    req = 1'b0; wr = 1'b1; addr = 16'h0020; wdata = 16'h1111;
    @(posedge clk); #1;
    wr = 1'b0; req = 1'b1;
    quiet_window("wr_no_req", ev0);

    do_write(16'h0002, 16'h00FF, 1'b1);
    do_read(16'h0002, 1'b0);

    for (int i = 0; i < 16; i++) do_write(16'(i), 16'($urandom), 1'b0);
    for (int n = 0; n < 40; n++) begin
      a = 16'($urandom_range(0, 15));
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0, 1: do_write(a, d, 1'b0);
        2:    do_read(a, 1'b0);
        default: begin
          ev0 = we_events;
          @(negedge clk);
          req = 1'b0; wr = $urandom_range(0, 1) == 1; rd = !wr; addr = a;
          @(posedge clk); #1;
          wr = 1'b0; rd = 1'b0; req = 1'b1;
          quiet_window("rand_ignored", ev0);
        end
      endcase
      nidle = $urandom_range(0, 2);
      repeat (nidle) @(negedge clk);
    end

    // Reset lands in the middle of the write strobe
    @(negedge clk);
    req = 1'b1; wr = 1'b1; addr = 16'h0005; wdata = 16'hA5A5;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midwr_pulse_active", sram_we_n, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midwr_we_n", sram_we_n, 1);
    check("midwr_dq_oe", sram_dq_oe, 0);
    check("midwr_ce_n", sram_ce_n, 1);
    check("midwr_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_read(16'h1234, 1'b0);
    do_read(16'h0007, 1'b0);

    check("oe_we_dq_overlap", overlap_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0d expected 0", 1);
    $fatal(1, "timeout");
  end

endmodule
